// File: rtl/step_pulse_gen.sv
// Single-cycle advance pulse for the display counter: a switch-selected
// auto rate, or one pulse per debounced press of the step button.
module step_pulse_gen #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       enable,
    input  logic       mode,
    input  logic [1:0] speed,
    input  logic       step_n,
    output logic       pulse
);

    localparam int RCW = $clog2(4 * CLK_HZ);
    localparam int DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [RCW-1:0] P1_M1 = RCW'(CLK_HZ - 1);
    localparam logic [RCW-1:0] P2_M1 = RCW'(2 * CLK_HZ - 1);
    localparam logic [RCW-1:0] P4_M1 = RCW'(4 * CLK_HZ - 1);
    localparam logic [DCW-1:0] DC_LAST = DCW'(DEB_CYCLES - 1);

    logic           r_pulse;
    logic [RCW-1:0] r_rc;
    logic [1:0]     r_speed_d;
    logic           r_s1;
    logic           r_s2;
    logic           r_deb;
    logic           r_deb_d;
    logic [DCW-1:0] r_dc;

    logic [RCW-1:0] w_reload;
    logic           w_same_speed;
    logic           w_rc_zero;
    logic           w_hit;
    logic           w_press;

    always_comb begin
        w_reload = '0;
        case (speed)
            2'b00:   w_reload = '0;
            2'b01:   w_reload = P1_M1;
            2'b10:   w_reload = P2_M1;
            default: w_reload = P4_M1;
        endcase
    end

    assign w_same_speed = (speed == r_speed_d);
    assign w_rc_zero    = (r_rc == '0);
    assign w_hit        = ~mode & enable & w_rc_zero & w_same_speed;
    // Only the debounced falling edge counts; release never advances.
    assign w_press      = r_deb_d & ~r_deb;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_deb   <= 1'b1;
            r_deb_d <= 1'b1;
            r_dc    <= '0;
        end else begin
            r_s1    <= step_n;
            r_s2    <= r_s1;
            r_deb_d <= r_deb;
            if (r_s2 == r_deb) begin
                r_dc <= '0;
            end else if (r_dc == DC_LAST) begin
                r_deb <= r_s2;
                r_dc  <= '0;
            end else begin
                r_dc <= r_dc + 1'b1;
            end
        end
    end

    // A speed change or manual mode parks the counter at a full reload.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_rc      <= '0;
            r_speed_d <= 2'b00;
            r_pulse   <= 1'b0;
        end else begin
            r_speed_d <= speed;
            r_pulse   <= mode ? w_press : w_hit;
            if (mode || !w_same_speed) begin
                r_rc <= w_reload;
            end else if (enable && w_rc_zero) begin
                r_rc <= w_reload;
            end else if (enable) begin
                r_rc <= r_rc - 1'b1;
            end
        end
    end

    assign pulse = r_pulse;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with CLK_HZ=4, DEB_CYCLES=3.
module tb_step_pulse_gen;

    logic       clock;
    logic       clear;
    logic       enable;
    logic       mode;
    logic [1:0] speed;
    logic       step_n;
    logic       pulse;

    int checks = 0;
    int errors = 0;

    step_pulse_gen #(
        .CLK_HZ    (4),
        .DEB_CYCLES(3)
    ) dut (
        .clock (clock),
        .clear (clear),
        .enable(enable),
        .mode  (mode),
        .speed (speed),
        .step_n(step_n),
        .pulse (pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // speed=01 (P=4) from reset release: pulses after edges 5, 9, 13
    task automatic base_run(input string pfx);
        for (int e = 1; e <= 14; e++) begin
            tick();
            chk($sformatf("%s_e%0d", pfx, e), pulse,
                (e == 5 || e == 9 || e == 13));
        end
    endtask

    initial begin
        int cnt;
        int first;
        int found;

        clear  = 1'b0;
        enable = 1'b1;
        mode   = 1'b0;
        speed  = 2'b01;
        step_n = 1'b1;
        tick();
        tick();
        chk("rst_pulse", pulse, 1'b0);
        clear = 1'b1;
        base_run("base");

        speed = 2'b00;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk($sformatf("full_e%0d", e), pulse, (e >= 2));
        end
        enable = 1'b0;
        tick();
        chk("en_drop0", pulse, 1'b0);
        tick();
        chk("en_drop1", pulse, 1'b0);
        enable = 1'b1;
        tick();
        chk("en_raise", pulse, 1'b1);

        speed = 2'b11;
        for (int f = 1; f <= 19; f++) begin
            if (f == 10) speed = 2'b01;
            tick();
            chk($sformatf("spd_f%0d", f), pulse, (f == 14 || f == 18));
        end

        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("man_idle%0d", i), pulse, 1'b0);
        end
        step_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("press_k%0d", i), pulse, (i == 5));
        end
        step_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("release%0d", i), pulse, 1'b0);
        end

        for (int i = 0; i < 10; i++) begin
            step_n = (i < 2) ? 1'b0 : 1'b1;
            tick();
            chk($sformatf("glitch%0d", i), pulse, 1'b0);
        end

        cnt = 0;
        for (int i = 0; i < 26; i++) begin
            step_n = (i < 20) ? logic'(i % 2) : 1'b1;
            tick();
            if (pulse) cnt++;
        end
        chk_int("toggle_cnt", cnt, 0);

        enable = 1'b0;
        cnt    = 0;
        first  = -1;
        step_n = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) step_n = 1'b1;
            tick();
            if (pulse) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        chk_int("hold_cnt", cnt, 1);
        chk_int("hold_edge", first, 5);

        mode   = 1'b0;
        enable = 1'b1;
        found  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pulse) begin
                found = 1;
                break;
            end
        end
        chk_int("auto_resume", found, 1);
        #2;
        clear = 1'b0;
        #1;
        chk("clr_async", pulse, 1'b0);
        tick();
        chk("clr_hold", pulse, 1'b0);
        clear = 1'b1;
        base_run("reclr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
